// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: iterative AES-128 controller that feeds one shared round datapath for NUM_ROUNDS rounds per block.
//   in_valid/in_ready/in_state/in_key    : plaintext and key accept handshake
//   out_valid/out_ready/out_state        : ciphertext offer handshake
//   dp_state/dp_key/dp_rcon/dp_final     : round datapath operands, held for ROUND_LAT cycles per round
//   dp_state_res/dp_key_res              : round datapath results, captured on the last phase of each round
//   busy/round_idx                       : block in flight, current round (0 outside RUN)
module aes_round_sequencer #(
    parameter int ROUND_LAT  = 2,
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic [127:0] dp_state,
    output logic [127:0] dp_key,
    output logic [7:0]   dp_rcon,
    output logic         dp_final,
    input  logic [127:0] dp_state_res,
    input  logic [127:0] dp_key_res,
    output logic         busy,
    output logic [3:0]   round_idx
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [3:0] PH_LAST  = 4'(ROUND_LAT - 1);
    localparam logic [3:0] RND_LAST = 4'(NUM_ROUNDS);
    state_t       state_q, state_d;
    logic [127:0] st_q, st_d, key_q, key_d, out_q, out_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   phase_q, phase_d, round_q, round_d;
    logic         accept, last_phase;
    assign in_ready   = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign accept     = in_valid && in_ready;
    assign last_phase = phase_q == PH_LAST;
    assign out_valid  = state_q == DONE;
    assign busy       = state_q == RUN;
    assign round_idx  = round_q;
    assign out_state  = out_q;
    assign dp_state   = st_q;
    assign dp_key     = key_q;
    assign dp_rcon    = rcon_q;
    assign dp_final   = busy && round_q == RND_LAST;
    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        key_d   = key_q;
        out_d   = out_q;
        rcon_d  = rcon_q;
        phase_d = phase_q;
        round_d = round_q;
        case (state_q)
            IDLE: ;
            RUN: begin
                phase_d = last_phase ? 4'd0 : phase_q + 4'd1;
                if (last_phase) begin
                    st_d    = dp_state_res;
                    key_d   = dp_key_res;
                    rcon_d  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                    round_d = round_q == RND_LAST ? 4'd0 : round_q + 4'd1;
                    state_d = round_q == RND_LAST ? DONE : RUN;
                    out_d   = round_q == RND_LAST ? dp_state_res : out_q;
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: begin
                state_d = IDLE;
                phase_d = 4'd0;
                round_d = 4'd0;
            end
        endcase
        // A DONE handshake with a new block pending goes straight back to RUN
        if (accept) begin
            st_d    = in_state ^ in_key;
            key_d   = in_key;
            rcon_d  = 8'h01;
            phase_d = 4'd0;
            round_d = 4'd1;
            state_d = RUN;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            st_q    <= '0;
            key_q   <= '0;
            out_q   <= '0;
            rcon_q  <= 8'h01;
            phase_q <= 4'd0;
            round_q <= 4'd0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            key_q   <= key_d;
            out_q   <= out_d;
            rcon_q  <= rcon_d;
            phase_q <= phase_d;
            round_q <= round_d;
        end
    end
endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: directed checks of the AES round sequencer against a behavioural AES round datapath.
module tb_aes_round_sequencer;
    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
    } vec_t;
    localparam logic [7:0] RC [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;
    logic a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 1, a_dp_final, a_busy;
    logic [127:0] a_in_state = 0, a_in_key = 0, a_out_state, a_dp_state, a_dp_key, a_sres, a_kres;
    logic [7:0] a_dp_rcon;
    logic [3:0] a_round;
    logic b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 1, b_dp_final, b_busy;
    logic [127:0] b_in_state = 0, b_in_key = 0, b_out_state, b_dp_state, b_dp_key, b_sres, b_kres;
    logic [7:0] b_dp_rcon;
    logic [3:0] b_round;
    logic [255:0] pa, pb0, pb1;
    int checks = 0, failures = 0;
    vec_t v [4];

    aes_round_sequencer #(.ROUND_LAT(2), .NUM_ROUNDS(10)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_state(a_in_state),
        .in_key(a_in_key), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_state(a_out_state),
        .dp_state(a_dp_state), .dp_key(a_dp_key), .dp_rcon(a_dp_rcon), .dp_final(a_dp_final),
        .dp_state_res(a_sres), .dp_key_res(a_kres), .busy(a_busy), .round_idx(a_round));
    aes_round_sequencer #(.ROUND_LAT(3), .NUM_ROUNDS(10)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_state(b_in_state),
        .in_key(b_in_key), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_state(b_out_state),
        .dp_state(b_dp_state), .dp_key(b_dp_key), .dp_rcon(b_dp_rcon), .dp_final(b_dp_final),
        .dp_state_res(b_sres), .dp_key_res(b_kres), .busy(b_busy), .round_idx(b_round));

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = xt(a);
        end
        return p;
    endfunction
    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] bb = {b, b};
        return bb[15-n -: 8];
    endfunction
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r = 8'h01, sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r = gmul(r, sq);
        end
        return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
    endfunction
    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction
    // returns {next_state, next_round_key}
    function automatic logic [255:0] rnd(input logic [127:0] s, input logic [127:0] k, input logic [7:0] rc, input logic fin);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [31:0] w0, w1, w2, w3;
        logic [127:0] nk, ns;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[4*c+r] = b[4*((c+r)%4)+r];
        if (!fin)
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        w0 = k[127:96] ^ subw({k[23:0], k[31:24]}) ^ {rc, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        nk = {w0, w1, w2, w3};
        for (int i = 0; i < 16; i++) ns[127-8*i -: 8] = t[i] ^ nk[127-8*i -: 8];
        return {ns, nk};
    endfunction

    // datapath models: ROUND_LAT-1 register stages so results settle exactly at the capture edge
    always @(posedge clk) begin
        pa  <= rnd(a_dp_state, a_dp_key, a_dp_rcon, a_dp_final);
        pb0 <= rnd(b_dp_state, b_dp_key, b_dp_rcon, b_dp_final);
        pb1 <= pb0;
    end
    assign a_sres = pa[255:128];
    assign a_kres = pa[127:0];
    assign b_sres = pb1[255:128];
    assign b_kres = pb1[127:0];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic send_a(input logic [127:0] p, input logic [127:0] k);
        int n = 0;
        a_in_state = p;
        a_in_key = k;
        a_in_valid = 1;
        while (!a_in_ready && n < 60) begin
            tick();
            n++;
        end
        tick();
        a_in_valid = 0;
        a_in_state = ~p;
        a_in_key = ~k;
    endtask
    task automatic wait_a(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!a_out_valid && n < 60);
    endtask

    initial begin
        int n;
        v[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        v[1] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32};
        v[2] = '{128'h6bc1bee22e409f96e93d7e117393172a, 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3ad77bb40d7a3660a89ecaf32466ef97};
        v[3] = '{128'hae2d8a571e03ac9c9eb76fac45af8e51, 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hf5d3d58503b9699de785895a96fdbaaf};
        repeat (3) tick();
        rst = 0;
        chk("reset_ctrl", {a_in_ready, a_out_valid, a_busy, a_round, a_dp_rcon, a_dp_final}, {1'b1, 1'b0, 1'b0, 4'd0, 8'h01, 1'b0});
        chk("reset_data", {a_dp_state ^ a_dp_key ^ a_out_state}, 128'h0);
        chk("reset_out_state", a_out_state, 128'h0);
        // C.1 with per-cycle monitoring of round control
        send_a(v[0].pt, v[0].key);
        chk("whiten_state", a_dp_state, 128'h00102030405060708090a0b0c0d0e0f0);
        chk("whiten_key", a_dp_key, v[0].key);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("rcon_seq_%0d", k), {a_round, a_dp_rcon, a_dp_final, a_out_valid, a_busy},
                {4'(k / 2 + 1), RC[k/2], k / 2 == 9, 1'b0, 1'b1});
            tick();
        end
        chk("c1_done", {a_out_valid, a_busy, a_round}, {1'b1, 1'b0, 4'd0});
        chk("c1_ct", a_out_state, v[0].ct);
        tick();
        chk("c1_idle", {a_out_valid, a_in_ready, a_busy}, 3'b010);
        // table of known-answer vectors
        for (int i = 0; i < 4; i++) begin
            send_a(v[i].pt, v[i].key);
            wait_a(n);
            chk($sformatf("vec%0d_latency", i), n, 20);
            chk($sformatf("vec%0d_ct", i), a_out_state, v[i].ct);
            tick();
            chk($sformatf("vec%0d_release", i), {a_out_valid, a_in_ready}, 2'b01);
        end
        // back-pressure: output held, in_valid pulses ignored
        a_out_ready = 0;
        send_a(v[1].pt, v[1].key);
        wait_a(n);
        chk("bp_latency", n, 20);
        for (int i = 0; i < 15; i++) begin
            a_in_valid = i[0];
            a_in_state = v[2].pt;
            a_in_key = v[2].key;
            tick();
            chk($sformatf("bp_hold_%0d", i), {a_out_valid, a_in_ready, a_busy, a_out_state}, {1'b1, 1'b0, 1'b0, v[1].ct});
        end
        a_in_valid = 0;
        a_out_ready = 1;
        tick();
        chk("bp_release", {a_out_valid, a_in_ready, a_busy}, 3'b010);
        tick();
        chk("bp_single", {a_out_valid, a_busy}, 2'b00);
        // back-to-back: three queued blocks, accept on each output handshake
        a_in_state = v[1].pt;
        a_in_key = v[1].key;
        a_in_valid = 1;
        tick();
        for (int j = 0; j < 3; j++) begin
            wait_a(n);
            chk($sformatf("b2b%0d_spacing", j), n, 20);
            chk($sformatf("b2b%0d_ct", j), a_out_state, v[j+1].ct);
            chk($sformatf("b2b%0d_in_ready", j), a_in_ready, 1'b1);
            if (j < 2) begin
                a_in_state = v[j+2].pt;
                a_in_key = v[j+2].key;
            end else a_in_valid = 0;
            tick();
            chk($sformatf("b2b%0d_next", j), {a_busy, a_out_valid, a_round}, j < 2 ? {1'b1, 1'b0, 4'd1} : {1'b0, 1'b0, 4'd0});
        end
        // reset during round 5
        send_a(v[0].pt, v[0].key);
        repeat (8) tick();
        chk("abort_round", a_round, 4'd5);
        rst = 1;
        tick();
        rst = 0;
        chk("abort_state", {a_in_ready, a_out_valid, a_busy, a_round}, {1'b1, 1'b0, 1'b0, 4'd0});
        send_a(v[0].pt, v[0].key);
        wait_a(n);
        chk("abort_next_latency", n, 20);
        chk("abort_next_ct", a_out_state, v[0].ct);
        tick();
        // ROUND_LAT=3 instance
        b_in_state = v[0].pt;
        b_in_key = v[0].key;
        b_in_valid = 1;
        tick();
        b_in_valid = 0;
        b_in_state = 0;
        for (int k = 0; k < 30; k++) begin
            chk($sformatf("lat3_seq_%0d", k), {b_round, b_dp_rcon, b_dp_final, b_out_valid, b_busy},
                {4'(k / 3 + 1), RC[k/3], k / 3 == 9, 1'b0, 1'b1});
            tick();
        end
        chk("lat3_done", {b_out_valid, b_busy, b_round}, {1'b1, 1'b0, 4'd0});
        chk("lat3_ct", b_out_state, v[0].ct);
        tick();
        chk("lat3_idle", {b_out_valid, b_in_ready}, 2'b01);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
